sat_addsub_serial: RTL and testbench

//  Multi-cycle, digit-serial 16-bit saturating adder/subtractor with a start/done handshake.
//  It is the sequential counterpart of the single-cycle combinational saturating add/sub.
//  It serves the multi-cycle execute path, where area matters more than latency.

---
 rtl/sat_addsub_pkg.sv | 19 +
 rtl/sat_addsub_serial_cla_4bit.sv | 27 ++
 rtl/sat_addsub_serial.sv | 112 +++++++++++
 tb/tb_sat_addsub_serial.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sat_addsub_pkg.sv
// Shared types and constants for the digit-serial saturating add/sub.
// Saturation is enabled by defining SAT_ADDSUB_SAT_EN at build time.
package sat_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    localparam int WIDTH_DEF = 16;
    localparam int DIGIT_DEF = 4;
    localparam int NDIG_DEF  = WIDTH_DEF / DIGIT_DEF;
    localparam int CNT_W     = $clog2(NDIG_DEF);

endpackage

// File: rtl/sat_addsub_serial_cla_4bit.sv
// One 4-bit carry-lookahead slice; the serial adder reuses it once per digit.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/sat_addsub_serial.sv
// Digit-serial 16-bit signed add/sub with start/done handshake and overflow flag.
// SAT_ADDSUB_SAT_EN defined: clamp on overflow; undefined: two's-complement wrap.
//
//   state | meaning
//   IDLE  | waiting for start, last result held
//   RUN   | one digit per cycle, LSB first, NDIG cycles
//   DONE  | result registered, may accept the next start
module sat_addsub_serial
    import sat_addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl
);
    localparam int NDIG = WIDTH / DIGIT;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic                     carry;
    logic [WIDTH-1:0]         a_sh;
    logic [WIDTH-1:0]         cb_sh;
    logic [WIDTH-DIGIT-1:0]   r_sh;
    logic                     a_msb;
    logic                     cb_msb;

    logic [DIGIT-1:0]         dig_sum;
    logic                     dig_cout;
    logic [WIDTH-1:0]         r_next;
    logic                     ovfl_next;
    logic [WIDTH-1:0]         sum_next;
    logic                     accept;

    cla_4bit u_cla (
        .a    (a_sh[DIGIT-1:0]),
        .b    (cb_sh[DIGIT-1:0]),
        .cin  (carry),
        .s    (dig_sum),
        .cout (dig_cout)
    );

    assign ready  = (state == ST_IDLE) || (state == ST_DONE);
    assign busy   = (state == ST_RUN);
    assign accept = start && ready;

    // Final digit is combined with the shifted-in partial result on the last RUN edge.
    assign r_next    = {dig_sum, r_sh};
    assign ovfl_next = (cb_msb ~^ a_msb) & (dig_sum[DIGIT-1] ^ a_msb);

`ifdef SAT_ADDSUB_SAT_EN
    assign sum_next = ovfl_next ? (a_msb ? SAT_NEG : SAT_POS) : r_next;
`else
    assign sum_next = r_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            cb_sh  <= '0;
            r_sh   <= '0;
            a_msb  <= 1'b0;
            cb_msb <= 1'b0;
            sum    <= '0;
            ovfl   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // done trails the DONE state by one cycle so back-to-back ops stay NDIG+1 apart
            done <= (state == ST_DONE);
            if (accept) begin
                a_sh   <= a;
                cb_sh  <= sub ? ~b : b;
                a_msb  <= a[WIDTH-1];
                cb_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                carry  <= sub;
                cnt    <= '0;
                state  <= ST_RUN;
            end else begin
                unique case (state)
                    ST_RUN: begin
                        a_sh  <= a_sh >> DIGIT;
                        cb_sh <= cb_sh >> DIGIT;
                        r_sh  <= r_next[WIDTH-1:DIGIT];
                        carry <= dig_cout;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(NDIG - 1)) begin
                            sum   <= sum_next;
                            ovfl  <= ovfl_next;
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    ST_IDLE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sat_addsub_serial.sv
// Scoreboard bench for sat_addsub_serial: driver queues expected results, monitor checks on done.
module tb_sat_addsub_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        ovfl;

    typedef struct {
        logic [15:0] s;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] held_sum = 16'h0;
    logic        held_ovfl = 1'b0;

    sat_addsub_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .ovfl  (ovfl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact signed arithmetic, then wrap or clamp.
    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
        exp_t e;
        int sa, sb, full;
        sa = int'($signed(ta));
        sb = int'($signed(tb));
        full = ts ? sa - sb : sa + sb;
        e.o = (full > 32767) || (full < -32768);
`ifdef SAT_ADDSUB_SAT_EN
        e.s = e.o ? ((full > 0) ? 16'h7FFF : 16'h8000) : full[15:0];
`else
        e.s = full[15:0];
`endif
        e.cyc = 0;
        return e;
    endfunction

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts, input bit hold);
        exp_t e;
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL ready_wait: ready=%0b after %0d cycles, expected 1", ready, n);
            return;
        end
        start = 1'b1;
        a = ta;
        b = tb;
        sub = ts;
        e = model(ta, tb, ts);
        e.cyc = cyc + 6;
        exp_q.push_back(e);
        @(negedge clk);
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("ready_after_accept", {31'b0, ready}, 32'd0);
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: done=1 with no pending op, sum=0x%0h", sum);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sum", {16'b0, sum}, {16'b0, mon_e.s});
                    check("ovfl", {31'b0, ovfl}, {31'b0, mon_e.o});
                    check("latency", cyc, mon_e.cyc);
                    held_sum = mon_e.s;
                    held_ovfl = mon_e.o;
                end
            end
            if (busy) begin
                check("sum_held", {16'b0, sum}, {16'b0, held_sum});
                check("ovfl_held", {31'b0, ovfl}, {31'b0, held_ovfl});
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_ovfl", {31'b0, ovfl}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h1111, 1'b0, 1'b0); drain();
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0); drain();
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0); drain();
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0); drain();
        do_op(16'h0000, 16'h8000, 1'b1, 1'b0); drain();
        do_op(16'hFFFF, 16'h8000, 1'b1, 1'b0); drain();

        // start while busy must be ignored
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        start = 1'b1;
        a = 16'h00FF;
        b = 16'h0001;
        sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held high through DONE: results every 5 cycles
        do_op(16'h0101, 16'h0202, 1'b0, 1'b1);
        do_op(16'h7000, 16'h7000, 1'b0, 1'b1);
        do_op(16'h8001, 16'h0002, 1'b1, 1'b1);
        do_op(16'h0003, 16'h0004, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = ($urandom_range(0, 3) == 0);
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        start = 1'b0;
        drain();

        // asynchronous reset in the middle of RUN
        do_op(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        held_sum = 16'h0;
        held_ovfl = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_sum", {16'b0, sum}, 32'd0);
        check("midrst_ovfl", {31'b0, ovfl}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
